// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared widths and controller state encoding for the 4x8 memory.
//  Revision : 1.0
// ============================================================================
package mem_pkg;

    localparam int MEM_DATA_W = 8;
    localparam int MEM_ADDR_W = 2;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        WR   = 3'd2,
        RD   = 3'd3,
        WAIT = 3'd4,
        RSP  = 3'd5
    } mem_init_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : mem_initiator
//  Purpose  : Sweeps memory to INIT_VAL after reset, then sequences client
//             read/write commands into memory strobes with registered outputs.
//  Revision : 1.0
// ============================================================================
module mem_initiator
    import mem_pkg::*;
#(
    parameter int                DATA_W   = MEM_DATA_W,
    parameter int                ADDR_W   = MEM_ADDR_W,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;
    localparam logic [2:0]        c_LAT_LAST  = 3'(RD_LAT - 1);

    mem_init_state_e   r_state,    w_state;
    logic [2:0]        r_lat_cnt,  w_lat_cnt;
    logic [ADDR_W-1:0] r_init_cnt, w_init_cnt;

    logic              w_cmd_ready;
    logic              w_rsp_valid;
    logic [DATA_W-1:0] w_rsp_data;
    logic              w_init_done;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_wr_en;
    logic              w_mem_rd_en;
    logic [DATA_W-1:0] w_mem_w_data;

    // Every output is computed one cycle ahead so it can come straight from a flop.
    always_comb begin
        w_state      = r_state;
        w_lat_cnt    = r_lat_cnt;
        w_init_cnt   = r_init_cnt;
        w_cmd_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        w_rsp_data   = rsp_data;
        w_init_done  = init_done;
        w_mem_addr   = mem_addr;
        w_mem_wr_en  = 1'b0;
        w_mem_rd_en  = 1'b0;
        w_mem_w_data = mem_w_data;

        case (r_state)
            INIT: begin
                // The last sweep write is already on the bus when this holds.
                if (mem_wr_en && (mem_addr == c_LAST_ADDR)) begin
                    w_state     = IDLE;
                    w_init_done = 1'b1;
                    w_cmd_ready = 1'b1;
                end else begin
                    w_mem_wr_en  = 1'b1;
                    w_mem_addr   = r_init_cnt;
                    w_mem_w_data = INIT_VAL;
                    if (r_init_cnt != c_LAST_ADDR) begin
                        w_init_cnt = r_init_cnt + 1'b1;
                    end
                end
            end
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    w_cmd_ready = 1'b0;
                    w_mem_addr  = cmd_addr;
                    if (cmd_we) begin
                        w_state      = WR;
                        w_mem_wr_en  = 1'b1;
                        w_mem_w_data = cmd_wdata;
                    end else begin
                        w_state     = RD;
                        w_mem_rd_en = 1'b1;
                    end
                end
            end
            WR: begin
                w_state     = IDLE;
                w_cmd_ready = 1'b1;
            end
            RD: begin
                w_state   = WAIT;
                w_lat_cnt = 3'd0;
            end
            WAIT: begin
                if (r_lat_cnt == c_LAT_LAST) begin
                    w_state     = RSP;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = mem_r_data;
                end else begin
                    w_lat_cnt = r_lat_cnt + 3'd1;
                end
            end
            RSP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_state     = IDLE;
                    w_cmd_ready = 1'b1;
                end
            end
            default: begin
                w_state = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= INIT;
            r_lat_cnt  <= 3'd0;
            r_init_cnt <= '0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            init_done  <= 1'b0;
            mem_addr   <= '0;
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_w_data <= '0;
        end else begin
            r_state    <= w_state;
            r_lat_cnt  <= w_lat_cnt;
            r_init_cnt <= w_init_cnt;
            cmd_ready  <= w_cmd_ready;
            rsp_valid  <= w_rsp_valid;
            rsp_data   <= w_rsp_data;
            init_done  <= w_init_done;
            mem_addr   <= w_mem_addr;
            mem_wr_en  <= w_mem_wr_en;
            mem_rd_en  <= w_mem_rd_en;
            mem_w_data <= w_mem_w_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_initiator
//  Purpose  : Self-checking bench for mem_initiator with a behavioural memory.
//  Revision : 1.0
// ============================================================================
module tb_mem_initiator;

    localparam int         DATA_W   = 8;
    localparam int         ADDR_W   = 2;
    localparam int         RD_LAT   = 1;
    localparam int         DEPTH    = 4;
    localparam logic [7:0] INIT_VAL = 8'h00;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              init_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_w_data;
    logic [DATA_W-1:0] mem_r_data;

    mem_initiator #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RD_LAT   (RD_LAT),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .init_done  (init_done),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: powers up with junk so only the sweep can make it INIT_VAL.
    logic [DATA_W-1:0] mem_q   [DEPTH];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    logic              seeded = 1'b0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'hEE;
            seeded <= 1'b1;
        end else if (mem_wr_en) begin
            mem_q[mem_addr] <= mem_w_data;
        end
        rd_pipe[0] <= mem_rd_en ? mem_q[mem_addr] : 8'h5A ^ rd_pipe[0];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_r_data = rd_pipe[RD_LAT-1];

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        if (mem_wr_en && mem_rd_en) begin
            failures++;
            $display("FAIL strobe_excl: got wr=%0b rd=%0b expected not both at %0t",
                     mem_wr_en, mem_rd_en, $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"},  cmd_ready,  0);
        chk({tag, "_rsp_valid"},  rsp_valid,  0);
        chk({tag, "_rsp_data"},   rsp_data,   0);
        chk({tag, "_init_done"},  init_done,  0);
        chk({tag, "_mem_addr"},   mem_addr,   0);
        chk({tag, "_mem_wr_en"},  mem_wr_en,  0);
        chk({tag, "_mem_rd_en"},  mem_rd_en,  0);
        chk({tag, "_mem_w_data"}, mem_w_data, 0);
    endtask

    // Release reset and check the four sweep writes and the IDLE entry cycle.
    task automatic release_and_sweep();
        rst = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            chk("sweep_wr_en",  mem_wr_en,  1);
            chk("sweep_addr",   mem_addr,   k);
            chk("sweep_wdata",  mem_w_data, INIT_VAL);
            chk("sweep_done",   init_done,  0);
            chk("sweep_ready",  cmd_ready,  0);
            chk("sweep_rspv",   rsp_valid,  0);
        end
        tick();
        chk("init_done_rise", init_done, 1);
        chk("ready_at_done",  cmd_ready, 1);
        chk("wr_after_sweep", mem_wr_en, 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_VAL;
    endtask

    // One command end to end; timing is measured from the accept edge.
    task automatic do_cmd(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp,
                          input int stall, input logic hold_valid, output int waited);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        waited    = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        tick();
        cmd_valid = 1'b0;
        chk("busy_ready", cmd_ready, 0);
        if (we) begin
            chk("wr_strobe", mem_wr_en,  1);
            chk("wr_no_rd",  mem_rd_en,  0);
            chk("wr_addr",   mem_addr,   addr);
            chk("wr_data",   mem_w_data, wdata);
            tick();
            chk("wr_pulse_end", mem_wr_en, 0);
            chk("wr_ready_back", cmd_ready, 1);
            ref_mem[addr] = wdata;
        end else begin
            chk("rd_strobe", mem_rd_en, 1);
            chk("rd_no_wr",  mem_wr_en, 0);
            chk("rd_addr",   mem_addr,  addr);
            for (int i = 0; i < RD_LAT; i++) begin
                tick();
                chk("wait_no_rsp", rsp_valid, 0);
                chk("wait_no_rd",  mem_rd_en, 0);
            end
            tick();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_data",  rsp_data,  exp);
            for (int s = 0; s < stall; s++) begin
                if (hold_valid) begin
                    cmd_valid = 1'b1;
                    cmd_we    = 1'b0;
                end
                tick();
                chk("stall_valid", rsp_valid, 1);
                chk("stall_data",  rsp_data,  exp);
                chk("stall_ready", cmd_ready, 0);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk("rsp_drop",   rsp_valid, 0);
            chk("rsp_ready_back", cmd_ready, 1);
        end
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int waited;
        logic              r_we;
        logic [ADDR_W-1:0] r_addr;
        logic [DATA_W-1:0] r_wdata;

        vecs[0] = '{1'b1, 2'd2, 8'h04, 8'h00};
        vecs[1] = '{1'b0, 2'd2, 8'h00, 8'h04};
        vecs[2] = '{1'b0, 2'd3, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 2'd0, 8'hA5, 8'h00};
        vecs[4] = '{1'b1, 2'd3, 8'h3C, 8'h00};
        vecs[5] = '{1'b0, 2'd0, 8'h00, 8'hA5};
        vecs[6] = '{1'b0, 2'd3, 8'h00, 8'h3C};
        vecs[7] = '{1'b0, 2'd1, 8'h00, 8'h00};

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        release_and_sweep();

        for (int v = 0; v < 8; v++) begin
            do_cmd(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp, 0, 1'b0, waited);
        end

        // Response back-pressure with the next command already waiting.
        do_cmd(1'b0, 2'd2, 8'h00, 8'h04, 5, 1'b1, waited);
        chk("held_cmd_ready", cmd_ready, 1);
        do_cmd(1'b0, 2'd2, 8'h00, 8'h04, 0, 1'b0, waited);
        chk("held_cmd_immediate", waited, 0);

        for (int n = 0; n < 40; n++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            r_wdata = 8'($urandom);
            do_cmd(r_we, r_addr, r_wdata, ref_mem[r_addr], $urandom_range(0, 3), 1'b0, waited);
        end

        // Reset in the middle of a read: nothing may come back and the sweep reruns.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 2'd0;
        waited    = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        chk("abort_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("abort_rd_strobe", mem_rd_en, 1);
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("abort");
        release_and_sweep();
        do_cmd(1'b0, 2'd0, 8'h00, INIT_VAL, 0, 1'b0, waited);
        do_cmd(1'b0, 2'd3, 8'h00, INIT_VAL, 0, 1'b0, waited);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
